// File: rtl/tick_period_meter.sv
`default_nettype none
// tick_period_meter: measures clkin cycles between tick_in rising edges, checks
// them against EXPECT +/- TOL, tracks lock and flags a missing tick. Rev 1.0
module tick_period_meter #(
  parameter int WIDTH      = 16,
  parameter int EXPECT     = 50000,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 65535,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             tick_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             locked,
  output logic             timeout
);

  localparam int LCW = $clog2(LOCK_COUNT + 1);
  localparam int LO  = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
  localparam int HI  = EXPECT + TOL;

  typedef enum logic [0:0] {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [LCW-1:0]   lock_cnt;
  logic             tick_d;

  logic             rise;
  logic             count_ok;
  logic [LCW-1:0]   lock_next;

  assign rise = tick_in & ~tick_d;

  // Window check is done one bit wider than the counter so the bounds never wrap.
  assign count_ok = ({1'b0, count} >= (WIDTH+1)'(LO)) &&
                    ({1'b0, count} <= (WIDTH+1)'(HI));

  always_comb begin
    lock_next = '0;
    if (count_ok) begin
      if (lock_cnt == LCW'(LOCK_COUNT))
        lock_next = lock_cnt;
      else
        lock_next = lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      in_range     <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      lock_cnt     <= '0;
      tick_d       <= 1'b1;
    end else begin
      tick_d       <= tick_in;
      period_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            count <= WIDTH'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period       <= count;
            period_valid <= 1'b1;
            in_range     <= count_ok;
            lock_cnt     <= lock_next;
            locked       <= (lock_next == LCW'(LOCK_COUNT));
            timeout      <= 1'b0;
            count        <= WIDTH'(1);
          end else if (count == WIDTH'(TIMEOUT)) begin
            // Missing tick: drop lock and wait for a fresh first edge.
            timeout  <= 1'b1;
            locked   <= 1'b0;
            lock_cnt <= '0;
            count    <= '0;
            state    <= IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
